// File: rtl/kb_event_writer_if.sv
`default_nettype none
// kb_event_writer_if: KB_INFO write port plus frame error pulse from the keyboard producer.
interface kb_event_writer_if;
   logic [31:0] kb_wraddr;
   logic [31:0] kb_wrdata;
   logic        kb_we;
   logic        frame_err;

   modport master (output kb_wraddr, output kb_wrdata, output kb_we, output frame_err);
   modport slave  (input  kb_wraddr, input  kb_wrdata, input  kb_we, input  frame_err);
endinterface
`default_nettype wire

// File: rtl/kb_event_writer.sv
`default_nettype none
// kb_event_writer: PS/2 device->host deserializer that folds E0/F0 prefixes, tracks modifiers and
// writes one packed event word per key event. Define KB_ASCII_EN to fill [23:16] with ASCII.
module kb_event_writer #(
   parameter logic [31:0] KB_INFO_ADDR   = 32'h0050_0000,
   parameter int          TIMEOUT_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   kb_event_writer_if.master bus
);
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ps2c_q, ps2c_d;
   logic [1:0]       ps2d_q, ps2d_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_ok_q, par_ok_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             ext_q, ext_d, brk_q, brk_d;
   logic             shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
   logic [7:0]       seq_q, seq_d;
   logic [31:0]      wrdata_q, wrdata_d;
   logic             we_q, we_d, err_q, err_d;

   logic             fall, sample, byte_done;
   logic [7:0]       ascii;

`ifdef KB_ASCII_EN
   function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic upper,
                                            input logic shift);
      logic [7:0] lc;
      logic [7:0] a;
      case (code)
         8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
         8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
         8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
         8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
         8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
         default: lc = 8'h00;
      endcase
      a = (lc != 8'h00 && upper) ? lc - 8'h20 : lc;
      // Digit row follows shift only; caps lock does not affect it.
      case (code)
         8'h45: a = shift ? 8'h29 : 8'h30;
         8'h16: a = shift ? 8'h21 : 8'h31;
         8'h1E: a = shift ? 8'h40 : 8'h32;
         8'h26: a = shift ? 8'h23 : 8'h33;
         8'h25: a = shift ? 8'h24 : 8'h34;
         8'h2E: a = shift ? 8'h25 : 8'h35;
         8'h36: a = shift ? 8'h5E : 8'h36;
         8'h3D: a = shift ? 8'h26 : 8'h37;
         8'h3E: a = shift ? 8'h2A : 8'h38;
         8'h46: a = shift ? 8'h28 : 8'h39;
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         8'h66: a = 8'h08;
         8'h0D: a = 8'h09;
         default: ;
      endcase
      return a;
   endfunction
`endif

   assign fall   = ps2c_q[2] & ~ps2c_q[1];
   assign sample = ps2d_q[1];

   always_comb begin
      state_d   = state_q;
      ps2c_d    = {ps2c_q[1:0], ps2_clk};
      ps2d_d    = {ps2d_q[0], ps2_data};
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_ok_d  = par_ok_q;
      to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
      ext_d     = ext_q;
      brk_d     = brk_q;
      shift_d   = shift_q;
      ctrl_d    = ctrl_q;
      caps_d    = caps_q;
      seq_d     = seq_q;
      wrdata_d  = wrdata_q;
      we_d      = 1'b0;
      err_d     = 1'b0;
      byte_done = 1'b0;
      ascii     = 8'h00;

      if (state_q != S_IDLE && !fall && to_cnt_q == TO_LAST) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         ext_d   = 1'b0;
         brk_d   = 1'b0;
      end else if (fall) begin
         case (state_q)
            S_IDLE: if (!sample) begin
               state_d   = S_DATA;
               bit_cnt_d = 3'd0;
            end
            S_DATA: begin
               shreg_d   = {sample, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_ok_d = ^{shreg_q, sample};
               state_d  = S_STOP;
            end
            default: begin
               state_d = S_IDLE;
               if (sample && par_ok_q) begin
                  byte_done = 1'b1;
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         endcase
      end

      // Decode happens in the stop-bit cycle so the write lands on the following edge.
      if (byte_done) begin
         if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shreg_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (!(shreg_q inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            if ((shreg_q == 8'h12 || shreg_q == 8'h59) && !ext_q) shift_d = ~brk_q;
            if (shreg_q == 8'h14)                                 ctrl_d  = ~brk_q;
            if (shreg_q == 8'h58 && !brk_q)                       caps_d  = ~caps_q;
`ifdef KB_ASCII_EN
            ascii = (brk_q || ext_q) ? 8'h00 : ascii_lut(shreg_q, shift_d ^ caps_d, shift_d);
`endif
            seq_d    = seq_q + 8'd1;
            wrdata_d = {seq_d, ascii, 3'b000, caps_d, ctrl_d, shift_d, brk_q, ext_q, shreg_q};
            we_d     = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ps2c_q    <= 3'b111;
         ps2d_q    <= 2'b11;
         bit_cnt_q <= 3'd0;
         shreg_q   <= 8'h00;
         par_ok_q  <= 1'b0;
         to_cnt_q  <= '0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         shift_q   <= 1'b0;
         ctrl_q    <= 1'b0;
         caps_q    <= 1'b0;
         seq_q     <= 8'h00;
         wrdata_q  <= 32'h0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ps2c_q    <= ps2c_d;
         ps2d_q    <= ps2d_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_ok_q  <= par_ok_d;
         to_cnt_q  <= to_cnt_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         shift_q   <= shift_d;
         ctrl_q    <= ctrl_d;
         caps_q    <= caps_d;
         seq_q     <= seq_d;
         wrdata_q  <= wrdata_d;
         we_q      <= we_d;
         err_q     <= err_d;
      end
   end

   assign bus.kb_wraddr = KB_INFO_ADDR;
   assign bus.kb_wrdata = wrdata_q;
   assign bus.kb_we     = we_q;
   assign bus.frame_err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_kb_event_writer.sv
`default_nettype none
// tb_kb_event_writer: drives PS/2 frames, predicts event words with a behavioural keyboard model and
// checks them through a queue-based scoreboard.
module tb_kb_event_writer;
   localparam int TO   = 300;
   localparam int HALF = 8;
`ifdef KB_ASCII_EN
   localparam logic [31:0] ASC_A = 32'h0041_0000;
   localparam logic [31:0] ASC_a = 32'h0061_0000;
`else
   localparam logic [31:0] ASC_A = 32'h0;
   localparam logic [31:0] ASC_a = 32'h0;
`endif
   localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
      8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] DIGIT_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] DIGIT_SH [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
      8'h26, 8'h2A, 8'h28};
   localparam logic [7:0] POOL [12] = '{8'h12, 8'h59, 8'h14, 8'h58, 8'hE0, 8'hF0, 8'hF0,
      8'hFA, 8'hAA, 8'h29, 8'h5A, 8'h66};

   logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   kb_event_writer_if bus ();

   kb_event_writer #(.KB_INFO_ADDR(32'h0050_0000), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus));

   always #5 clk = ~clk;

   int          tests = 0, fails = 0, exp_err = 0, err_seen = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_word = 32'h0, popped;
   bit          checking = 1'b0;
   logic        prev_we = 1'b0, prev_err = 1'b0;

   logic        m_ext, m_brk, m_shift, m_ctrl, m_caps;
   logic [7:0]  m_seq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (checking) begin
         if (bus.kb_we) begin
            check("we_single_cycle", {31'b0, prev_we}, 32'h0);
            check("wraddr", bus.kb_wraddr, 32'h0050_0000);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got %08h expected no write", bus.kb_wrdata);
            end else begin
               popped = exp_q.pop_front();
               check("event_word", bus.kb_wrdata, popped);
               last_word = popped;
            end
         end else begin
            check("wrdata_held", bus.kb_wrdata, last_word);
         end
         if (bus.frame_err) begin
            err_seen++;
            check("err_single_cycle", {31'b0, prev_err}, 32'h0);
         end
      end
      prev_we  = bus.kb_we;
      prev_err = bus.frame_err;
   end

   function automatic logic [7:0] ascii_ref(input logic [7:0] c);
`ifdef KB_ASCII_EN
      if (m_brk || m_ext) return 8'h00;
      for (int i = 0; i < 26; i++)
         if (c == LETTER_SC[i]) return ((m_shift ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (c == DIGIT_SC[i]) return m_shift ? DIGIT_SH[i] : 8'h30 + 8'(i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h5A) return 8'h0D;
      if (c == 8'h66) return 8'h08;
      if (c == 8'h0D) return 8'h09;
`endif
      return 8'h00;
   endfunction

   task automatic model_reset();
      {m_ext, m_brk, m_shift, m_ctrl, m_caps} = '0;
      m_seq = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] c, output bit wr, output logic [31:0] w);
      wr = 1'b0;
      w  = 32'h0;
      if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'hF0) m_brk = 1'b1;
      else if (!(c inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
         if ((c == 8'h12 || c == 8'h59) && !m_ext) m_shift = !m_brk;
         if (c == 8'h14) m_ctrl = !m_brk;
         if (c == 8'h58 && !m_brk) m_caps = !m_caps;
         m_seq = m_seq + 8'd1;
         w  = {m_seq, ascii_ref(c), 3'b000, m_caps, m_ctrl, m_shift, m_brk, m_ext, c};
         wr = 1'b1;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_bits(input logic [7:0] code, input bit bad, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^code) ^ bad, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (3 * HALF) @(posedge clk);
   endtask

   // Directed: push a hand-computed word (if any) while keeping the model in step.
   task automatic send_exp(input logic [7:0] code, input bit has, input logic [31:0] word);
      bit          wr;
      logic [31:0] w;
      model_byte(code, wr, w);
      if (has) exp_q.push_back(word);
      send_bits(code, 1'b0, 11);
   endtask

   task automatic send_rand(input logic [7:0] code, input bit bad);
      bit          wr;
      logic [31:0] w;
      if (bad) begin
         exp_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         model_byte(code, wr, w);
         if (wr) exp_q.push_back(w);
      end
      send_bits(code, bad, 11);
   endtask

   task automatic do_reset();
      checking = 1'b0;
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_wrdata", bus.kb_wrdata, 32'h0);
      check("rst_we", {31'b0, bus.kb_we}, 32'h0);
      check("rst_err", {31'b0, bus.frame_err}, 32'h0);
      check("rst_wraddr", bus.kb_wraddr, 32'h0050_0000);
      check("rst_queue_empty", exp_q.size(), 32'h0);
      last_word = 32'h0;
      model_reset();
      checking = 1'b1;
   endtask

   initial begin
      logic [7:0] code;
      int         r;
      model_reset();
      do_reset();
      send_exp(8'h1C, 1'b1, 32'h0100_001C | ASC_a);
      repeat (10) @(posedge clk);
      check("first_pending", exp_q.size(), 32'h0);

      do_reset();
      send_exp(8'h12, 1'b1, 32'h0100_0412);
      send_exp(8'h1C, 1'b1, 32'h0200_041C | ASC_A);
      send_exp(8'hF0, 1'b0, 32'h0);
      send_exp(8'h12, 1'b1, 32'h0300_0212);
      send_exp(8'hE0, 1'b0, 32'h0);
      send_exp(8'hF0, 1'b0, 32'h0);
      send_exp(8'h75, 1'b1, 32'h0400_0375);
      send_exp(8'h58, 1'b1, 32'h0500_1058);
      send_exp(8'hF0, 1'b0, 32'h0);
      send_exp(8'h58, 1'b1, 32'h0600_1258);
      send_exp(8'h1C, 1'b1, 32'h0700_101C | ASC_A);

      exp_err++;
      send_bits(8'h1C, 1'b1, 11);
      check("parity_err_count", err_seen, exp_err);
      send_exp(8'h1C, 1'b1, 32'h0800_101C | ASC_A);

      // Partial frame: start bit plus four data bits, then the clock stops.
      send_bits(8'h1C, 1'b0, 5);
      repeat (TO + 20) @(posedge clk);
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      check("timeout_err_count", err_seen, exp_err);
      send_exp(8'h1C, 1'b1, 32'h0900_101C | ASC_A);

      for (int n = 0; n < 140; n++) begin
         r = $urandom_range(0, 11);
         if (r < 4)      code = LETTER_SC[$urandom_range(0, 25)];
         else if (r < 5) code = DIGIT_SC[$urandom_range(0, 9)];
         else            code = POOL[$urandom_range(0, 11)];
         send_rand(code, $urandom_range(0, 11) == 0);
      end

      repeat (50) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 32'h0);
      check("final_err_count", err_seen, exp_err);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
